// File: rtl/cm_notification_tx.sv
`default_nettype none
// ============================================================================
// Module      : cm_notification_tx
// Description : Collects error / config-notification / VGA-notification events
//               from the configuration manager and serializes each one as a
//               3-byte frame (tag, payload, tag^payload) into the UART TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module cm_notification_tx #(
  parameter int UART_DATA_WIDTH           = 8,
  parameter int CONFIG_NOTIFICATION_WIDTH = 8,
  parameter int CONFIG_ERROR_WIDTH        = 8,
  parameter int VGA_NOTIFICATION_WIDTH    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
  input  logic                                 Error_Valid,
  input  logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
  input  logic                                 Config_Notification_Valid,
  input  logic [VGA_NOTIFICATION_WIDTH-1:0]    VGA_Notification,
  input  logic                                 VGA_Notification_Valid,
  input  logic                                 TX_Full,
  output logic [UART_DATA_WIDTH-1:0]           TXD_Data,
  output logic                                 TX_Wr,
  output logic                                 Busy
);

  // Tag bytes; bit 0 is replaced by the source's lost flag at selection time.
  localparam logic [7:0] c_TAG_ERR = 8'hE0;
  localparam logic [7:0] c_TAG_CFG = 8'hC0;
  localparam logic [7:0] c_TAG_VGA = 8'hD0;

  // Slot index: 0 = ERR, 1 = CFG, 2 = VGA (also the fixed priority order).
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TAG     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHECK   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      pend_q, pend_d;
  logic [2:0]      lost_q, lost_d;
  logic [2:0][7:0] pay_q, pay_d;
  logic [7:0]      tag_q, tag_d;
  logic [7:0]      fpay_q, fpay_d;

  logic [2:0]      w_valid;
  logic [2:0][7:0] w_code;
  logic [2:0]      w_clr;
  logic [UART_DATA_WIDTH-1:0] w_txd;

  // Narrow codes are zero-extended into the 8-bit payload slots.
  assign w_valid   = {VGA_Notification_Valid, Config_Notification_Valid, Error_Valid};
  assign w_code[0] = 8'(Config_Error);
  assign w_code[1] = 8'(Config_Notification);
  assign w_code[2] = 8'(VGA_Notification);

  // Pending slots: a capture always wins over a same-cycle clear and only an
  // un-cleared older event counts as lost.
  always_comb begin
    pend_d = pend_q;
    lost_d = lost_q;
    pay_d  = pay_q;
    for (int i = 0; i < 3; i++) begin
      if (w_clr[i]) begin
        pend_d[i] = 1'b0;
        lost_d[i] = 1'b0;
      end
      if (w_valid[i]) begin
        pend_d[i] = 1'b1;
        pay_d[i]  = w_code[i];
        if (pend_q[i] && !w_clr[i]) begin
          lost_d[i] = 1'b1;
        end
      end
    end
  end

  // Frame sequencer: select a source in IDLE, then emit three bytes,
  // holding each one for as long as the FIFO reports full.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    fpay_d  = fpay_q;
    w_clr   = 3'b000;
    w_txd   = '0;
    case (state_q)
      S_IDLE: begin
        if (pend_q[0]) begin
          w_clr   = 3'b001;
          tag_d   = c_TAG_ERR | {7'd0, lost_q[0]};
          fpay_d  = pay_q[0];
          state_d = S_TAG;
        end else if (pend_q[1]) begin
          w_clr   = 3'b010;
          tag_d   = c_TAG_CFG | {7'd0, lost_q[1]};
          fpay_d  = pay_q[1];
          state_d = S_TAG;
        end else if (pend_q[2]) begin
          w_clr   = 3'b100;
          tag_d   = c_TAG_VGA | {7'd0, lost_q[2]};
          fpay_d  = pay_q[2];
          state_d = S_TAG;
        end
      end
      S_TAG: begin
        w_txd = tag_q;
        if (!TX_Full) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        w_txd = fpay_q;
        if (!TX_Full) state_d = S_CHECK;
      end
      S_CHECK: begin
        w_txd = tag_q ^ fpay_q;
        if (!TX_Full) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, slot and frame registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      lost_q  <= '0;
      pay_q   <= '0;
      tag_q   <= '0;
      fpay_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      lost_q  <= lost_d;
      pay_q   <= pay_d;
      tag_q   <= tag_d;
      fpay_q  <= fpay_d;
    end
  end

  // Write strobe is gated combinationally so a full FIFO or reset blocks it
  // in the very same cycle.
  assign TX_Wr    = (state_q != S_IDLE) & ~TX_Full & ~rst;
  assign TXD_Data = w_txd;
  assign Busy     = (state_q != S_IDLE) | (|pend_q);

endmodule
`default_nettype wire

// File: tb/tb_cm_notification_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cm_notification_tx
// Description : Self-checking bench for cm_notification_tx: a queue-based
//               frame model checked every cycle, directed scenarios with
//               literal byte expectations, then randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cm_notification_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] Config_Error = '0;
  logic       Error_Valid = 1'b0;
  logic [7:0] Config_Notification = '0;
  logic       Config_Notification_Valid = 1'b0;
  logic [7:0] VGA_Notification = '0;
  logic       VGA_Notification_Valid = 1'b0;
  logic       TX_Full = 1'b0;
  logic [7:0] TXD_Data;
  logic       TX_Wr;
  logic       Busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Reference model: per-source pending slots and the bytes of the frame in flight.
  logic [2:0]  m_pend = '0;
  logic [2:0]  m_lost = '0;
  logic [7:0]  m_pay [3];
  logic [7:0]  m_q [$];

  // Log of bytes the DUT actually wrote, with the cycle of each write.
  logic [7:0]  log_b [$];
  int          log_c [$];

  cm_notification_tx #(
    .UART_DATA_WIDTH(8),
    .CONFIG_NOTIFICATION_WIDTH(8),
    .CONFIG_ERROR_WIDTH(8),
    .VGA_NOTIFICATION_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Config_Error(Config_Error),
    .Error_Valid(Error_Valid),
    .Config_Notification(Config_Notification),
    .Config_Notification_Valid(Config_Notification_Valid),
    .VGA_Notification(VGA_Notification),
    .VGA_Notification_Valid(VGA_Notification_Valid),
    .TX_Full(TX_Full),
    .TXD_Data(TXD_Data),
    .TX_Wr(TX_Wr),
    .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] tag_base(input int i);
    case (i)
      0:       return 8'hE0;
      1:       return 8'hC0;
      default: return 8'hD0;
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs presented this cycle.
  task automatic model_step();
    int         sel;
    logic [2:0] v;
    logic [7:0] code [3];
    logic [7:0] t;
    if (rst) begin
      m_q.delete();
      m_pend = '0;
      m_lost = '0;
      for (int i = 0; i < 3; i++) m_pay[i] = '0;
      chk_en = 1'b1;
      return;
    end
    sel = -1;
    if (m_q.size() == 0) begin
      for (int i = 2; i >= 0; i--) if (m_pend[i]) sel = i;
    end
    if (m_q.size() > 0 && !TX_Full) void'(m_q.pop_front());
    if (sel >= 0) begin
      t = tag_base(sel) | {7'd0, m_lost[sel]};
      m_q.push_back(t);
      m_q.push_back(m_pay[sel]);
      m_q.push_back(t ^ m_pay[sel]);
    end
    v = {VGA_Notification_Valid, Config_Notification_Valid, Error_Valid};
    code[0] = Config_Error;
    code[1] = Config_Notification;
    code[2] = VGA_Notification;
    for (int i = 0; i < 3; i++) begin
      if (v[i]) begin
        m_lost[i] = (sel == i) ? 1'b0 : (m_lost[i] | m_pend[i]);
        m_pend[i] = 1'b1;
        m_pay[i]  = code[i];
      end else if (sel == i) begin
        m_pend[i] = 1'b0;
        m_lost[i] = 1'b0;
      end
    end
  endtask

  // Compare process: check outputs mid-cycle, then step the model at the edge.
  always begin
    logic       exp_wr;
    logic [7:0] exp_d;
    logic       exp_busy;
    @(negedge clk);
    #2;
    if (chk_en) begin
      exp_wr   = (m_q.size() > 0) && !TX_Full && !rst;
      exp_d    = (m_q.size() > 0) ? m_q[0] : 8'h00;
      exp_busy = (m_q.size() > 0) || (|m_pend);
      chk("TX_Wr", {31'd0, TX_Wr}, {31'd0, exp_wr});
      chk("TXD_Data", {24'd0, TXD_Data}, {24'd0, exp_d});
      chk("Busy", {31'd0, Busy}, {31'd0, exp_busy});
    end
    if (TX_Wr === 1'b1) begin
      log_b.push_back(TXD_Data);
      log_c.push_back(cyc);
    end
    @(posedge clk);
    model_step();
    cyc++;
  end

  // Move to the next cycle with all strobes deasserted.
  task automatic go();
    @(negedge clk);
    Error_Valid               = 1'b0;
    Config_Notification_Valid = 1'b0;
    VGA_Notification_Valid    = 1'b0;
  endtask

  task automatic check_log(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, log_b.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_b.size(); i++)
      chk($sformatf("%s_b%0d", name, i), {24'd0, log_b[i]}, {24'd0, exp[i]});
  endtask

  task automatic clear_log();
    log_b.delete();
    log_c.delete();
  endtask

  initial begin
    int s;
    logic [7:0] e [$];
    for (int i = 0; i < 3; i++) m_pay[i] = '0;

    // Reset and reset values
    rst = 1'b1;
    go(); go();
    rst = 1'b0;
    #3;
    chk("rst_TX_Wr", {31'd0, TX_Wr}, 32'd0);
    chk("rst_TXD", {24'd0, TXD_Data}, 32'h00);
    chk("rst_Busy", {31'd0, Busy}, 32'd0);
    go(); go();

    // Single CFG event: latency and byte values
    clear_log();
    go(); Config_Notification = 8'h05; Config_Notification_Valid = 1'b1; s = cyc;
    go(); go();
    #3;
    chk("t1_wr_c2", {31'd0, TX_Wr}, 32'd1);
    chk("t1_tag_c2", {24'd0, TXD_Data}, 32'hC0);
    go(); go(); go();
    #3;
    chk("t1_busy_c5", {31'd0, Busy}, 32'd0);
    repeat (3) go();
    e = '{8'hC0, 8'h05, 8'hC5};
    check_log("t1", e);
    if (log_c.size() == 3) begin
      chk("t1_cyc0", log_c[0] - s, 2);
      chk("t1_cyc2", log_c[2] - s, 4);
    end

    // Simultaneous events from all sources
    clear_log();
    go();
    Config_Error = 8'h11; Error_Valid = 1'b1;
    Config_Notification = 8'h22; Config_Notification_Valid = 1'b1;
    VGA_Notification = 8'h33; VGA_Notification_Valid = 1'b1;
    s = cyc;
    repeat (16) go();
    e = '{8'hE0, 8'h11, 8'hF1, 8'hC0, 8'h22, 8'hE2, 8'hD0, 8'h33, 8'hE3};
    check_log("t2", e);
    if (log_c.size() == 9) begin
      chk("t2_cfg_start", log_c[3] - s, 6);
      chk("t2_vga_start", log_c[6] - s, 10);
    end

    // Backpressure during cycles 2..6
    clear_log();
    go(); Config_Error = 8'h7A; Error_Valid = 1'b1; s = cyc;
    go();
    go(); TX_Full = 1'b1;
    go(); go();
    #3;
    chk("t3_stall_wr", {31'd0, TX_Wr}, 32'd0);
    chk("t3_stall_d", {24'd0, TXD_Data}, 32'hE0);
    go(); go();
    go(); TX_Full = 1'b0;
    repeat (6) go();
    e = '{8'hE0, 8'h7A, 8'h9A};
    check_log("t3", e);
    if (log_c.size() == 3) chk("t3_cyc0", log_c[0] - s, 7);

    // Overflow of the VGA slot while an ERR frame is in flight
    clear_log();
    go(); Config_Error = 8'h55; Error_Valid = 1'b1;
    go();
    go(); VGA_Notification = 8'h01; VGA_Notification_Valid = 1'b1;
    go(); VGA_Notification = 8'h02; VGA_Notification_Valid = 1'b1;
    repeat (9) go();
    VGA_Notification = 8'h04; VGA_Notification_Valid = 1'b1;
    repeat (8) go();
    e = '{8'hE0, 8'h55, 8'hB5, 8'hD1, 8'h02, 8'hD3, 8'hD0, 8'h04, 8'hD4};
    check_log("t4", e);

    // Capture and clear of the same slot in one cycle
    clear_log();
    go(); Config_Notification = 8'h10; Config_Notification_Valid = 1'b1;
    go(); Config_Notification = 8'h20; Config_Notification_Valid = 1'b1;
    repeat (12) go();
    e = '{8'hC0, 8'h10, 8'hD0, 8'hC0, 8'h20, 8'hE0};
    check_log("t5", e);

    // Reset in the PAYLOAD cycle
    clear_log();
    go(); VGA_Notification = 8'h09; VGA_Notification_Valid = 1'b1;
    go(); Config_Notification = 8'h03; Config_Notification_Valid = 1'b1;
    go();
    go(); rst = 1'b1;
    #3;
    chk("t6_wr_in_rst", {31'd0, TX_Wr}, 32'd0);
    go(); rst = 1'b0;
    #3;
    chk("t6_busy", {31'd0, Busy}, 32'd0);
    chk("t6_txd", {24'd0, TXD_Data}, 32'h00);
    chk("t6_wr", {31'd0, TX_Wr}, 32'd0);
    repeat (4) go();
    e = '{8'hD0};
    check_log("t6a", e);
    clear_log();
    go(); Config_Notification = 8'h07; Config_Notification_Valid = 1'b1;
    repeat (8) go();
    e = '{8'hC0, 8'h07, 8'hC7};
    check_log("t6b", e);

    // Randomized traffic, checked cycle by cycle against the model
    for (int n = 0; n < 3000; n++) begin
      go();
      Config_Error        = 8'($urandom);
      Config_Notification = 8'($urandom);
      VGA_Notification    = 8'($urandom);
      Error_Valid               = ($urandom_range(0, 7) == 0);
      Config_Notification_Valid = ($urandom_range(0, 5) == 0);
      VGA_Notification_Valid    = ($urandom_range(0, 5) == 0);
      TX_Full = ($urandom_range(0, 9) < 3);
      rst     = ($urandom_range(0, 399) == 0);
    end
    go();
    rst = 1'b0;
    TX_Full = 1'b0;
    repeat (20) go();
    #3;
    chk("final_busy", {31'd0, Busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cm_notification_tx.md
# cm_notification_tx

Transmit-side companion of the configuration manager: collects the error, configuration-notification and VGA-notification events the manager raises and serializes each one as a 3-byte frame into the UART TX FIFO. The manager reads command bytes out of the RX FIFO; this block writes response bytes into the TX FIFO. It sits between the manager's notification/error outputs and the UART transmitter's input FIFO.

## Interface
- UART_DATA_WIDTH, 8, TX FIFO byte width; fixed at 8.
- CONFIG_NOTIFICATION_WIDTH, 8, config notification code width; ≤ 8.
- CONFIG_ERROR_WIDTH, 8, config error code width; ≤ 8.
- VGA_NOTIFICATION_WIDTH, 8, VGA notification code width; ≤ 8.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- Config_Error  in  CONFIG_ERROR_WIDTH  error code; sampled when Error_Valid=1.
- Error_Valid  in  1  one-cycle error event strobe.
- Config_Notification  in  CONFIG_NOTIFICATION_WIDTH  notification code.
- Config_Notification_Valid  in  1  one-cycle strobe.
- VGA_Notification  in  VGA_NOTIFICATION_WIDTH  VGA notification code.
- VGA_Notification_Valid  in  1  one-cycle strobe.
- TX_Full  in  1  TX FIFO full; no write may be issued while high.
- TXD_Data  out  UART_DATA_WIDTH  byte to write.
- TX_Wr  out  1  write enable; a byte is accepted at every rising edge with TX_Wr=1.
- Busy  out  1  high when state≠IDLE or any pending flag is set.

## Operation
- One pending slot per source (ERR, CFG, VGA): pend flag, 8-bit payload (code zero-extended), lost flag.
- Capture: Valid=1 sets pend and overwrites payload. If pend is already set and not being cleared that cycle, lost is also set (older event dropped, newest kept).
- Capture and clear in the same cycle for the same source: the capture wins. pend stays 1, the new payload is stored, and lost is not set.
- FSM states: IDLE, TAG, PAYLOAD, CHECK.
  - IDLE: if any pend is set, select by fixed priority ERR > CFG > VGA. Latch tag/payload into the frame registers, clear that source's pend and lost, and go to TAG. Otherwise stay.
  - TAG: TXD_Data=tag. If TX_Full=0, write and go to PAYLOAD; else hold.
  - PAYLOAD: TXD_Data=payload. Same stall rule; go to CHECK.
  - CHECK: TXD_Data=tag^payload. Same stall rule; go to IDLE.
- Tag byte: ERR=0xE0, CFG=0xC0, VGA=0xD0. Bit0 = lost flag of that source at selection time.
- TX_Wr = (state∈{TAG,PAYLOAD,CHECK}) & ~TX_Full & ~rst. This is combinational, so a write is never issued into a full FIFO or during reset.
- TXD_Data is 0x00 in IDLE.
- Events arriving while a frame is in flight only update the pending slots. The frame in flight is never altered.

## Timing
- Reset values (state after any cycle with rst=1): state=IDLE; all pend, lost and frame registers 0; TX_Wr=0; TXD_Data=0x00; Busy=0.
- Reset mid-frame: the frame is truncated and remaining bytes are never sent. Pending events are discarded.
- Latency with TX_Full=0: strobe in cycle 0 → pend set at the end of cycle 0 → IDLE selects in cycle 1 → TAG written in cycle 2, PAYLOAD in cycle 3, CHECK in cycle 4 → IDLE in cycle 5.
- Throughput: 4 cycles per frame minimum (1 IDLE + 3 write cycles).
- TX_Full stalls hold state and TXD_Data stable for any duration. The write occurs in the first cycle with TX_Full=0.
- Simultaneous strobes from all three sources are all captured. Frames are emitted in ERR, CFG, VGA order, back to back.
- Busy is registered-state based. It goes 0 in the cycle after CHECK is written if nothing is pending.

## Test plan
- Single CFG event: code 0x05 in cycle 0, TX_Full=0 → bytes C0, 05, C5 with TX_Wr high in cycles 2, 3, 4; Busy low from cycle 5.
- Simultaneous events: ERR 0x11, CFG 0x22 and VGA 0x33 in the same cycle → frames E0 11 F1, then C0 22 E2, then D0 33 E3, with one IDLE cycle between frames.
- Backpressure: TX_Full=1 during cycles 2–6 for ERR 0x7A → TX_Wr stays 0 and TXD_Data holds E0. Bytes E0, 7A, 9A are written in cycles 7, 8, 9.
- Overflow: VGA 0x01 then VGA 0x02 while an ERR frame is in flight → only D1 02 D3 is sent for VGA. The next VGA event 0x04 then yields D0 04 D4.
- Same-cycle capture/clear: CFG 0x10 pending, and CFG 0x20 strobes in the IDLE cycle that selects 0x10 → frame C0 10 D0, then C0 20 E0 (lost=0).
- Reset mid-frame: rst asserted in the PAYLOAD cycle → no write in that cycle and no CHECK byte. All outputs hold reset values, Busy=0, and the next event produces a full frame.
